// File: rtl/vx_stream_lru_arb.sv
// N-to-1 valid/ready stream arbiter: least-recently-granted matrix priority,
// packet lock on last flags, output registered through a 2-entry FIFO.
module vx_stream_lru_arb #(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 32,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQS-1:0]          i_valid_in,
    input  logic [NUM_REQS*DATAW-1:0]    i_data_in,
    input  logic [NUM_REQS-1:0]          i_last_in,
    output logic [NUM_REQS-1:0]          o_ready_in,
    output logic                         o_valid_out,
    output logic [DATAW-1:0]             o_data_out,
    output logic                         o_last_out,
    output logic [LOG_NUM_REQS-1:0]      o_sel_out,
    input  logic                         i_ready_out
);

    logic [1:0]              r_count;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [DATAW-1:0]        r_data [2];
    logic                    r_last [2];
    logic [LOG_NUM_REQS-1:0] r_sel  [2];

    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic [LOG_NUM_REQS-1:0] w_idx;
    logic [NUM_REQS-1:0]     w_ready;
    logic [DATAW-1:0]        w_push_data;
    logic                    w_push_last;

    assign w_full = (r_count == 2'd2);

    generate
        if (NUM_REQS > 1) begin : g_arb
            // r_prio[i][j] = 1 means stream i currently beats stream j.
            logic [NUM_REQS-1:0]     r_prio [NUM_REQS];
            logic                    r_locked;
            logic [LOG_NUM_REQS-1:0] r_lock_idx;
            logic [NUM_REQS-1:0]     w_win;
            logic [NUM_REQS-1:0]     w_grant;

            for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_win
                assign w_win[gi] = i_valid_in[gi] &&
                    (&(r_prio[gi] | ~i_valid_in | (NUM_REQS'(1) << gi)));
            end

            assign w_grant = r_locked ? (NUM_REQS'(1) << r_lock_idx) : w_win;
            assign w_ready = w_grant & {NUM_REQS{~w_full}};

            always_comb begin
                w_idx = '0;
                for (int i = 0; i < NUM_REQS; i++) begin
                    if (w_grant[i]) begin
                        w_idx = LOG_NUM_REQS'(i);
                    end
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_locked   <= 1'b0;
                    r_lock_idx <= '0;
                end else if (w_push) begin
                    r_locked   <= !w_push_last;
                    r_lock_idx <= w_idx;
                end
            end

            // On a packet's final beat the winner drops below everyone else.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < NUM_REQS; i++) begin
                        for (int j = 0; j < NUM_REQS; j++) begin
                            r_prio[i][j] <= (j > i);
                        end
                    end
                end else if (w_push && w_push_last) begin
                    for (int i = 0; i < NUM_REQS; i++) begin
                        if (LOG_NUM_REQS'(i) == w_idx) begin
                            r_prio[i] <= '0;
                        end else begin
                            r_prio[i][w_idx] <= 1'b1;
                        end
                    end
                end
            end
        end else begin : g_single
            assign w_idx   = '0;
            assign w_ready = {NUM_REQS{~w_full}};
        end
    endgenerate

    assign o_ready_in  = w_ready;
    assign w_push      = |(i_valid_in & w_ready);
    assign w_push_data = i_data_in[int'(w_idx)*DATAW +: DATAW];
    assign w_push_last = i_last_in[w_idx];
    assign w_pop       = o_valid_out && i_ready_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_last[i] <= 1'b0;
                r_sel[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_push_data;
                r_last[r_wr_ptr] <= w_push_last;
                r_sel[r_wr_ptr]  <= w_idx;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign o_valid_out = (r_count != 2'd0);
    assign o_data_out  = r_data[r_rd_ptr];
    assign o_last_out  = r_last[r_rd_ptr];
    assign o_sel_out   = r_sel[r_rd_ptr];

endmodule

// File: tb/tb_vx_stream_lru_arb.sv
// Directed bench for vx_stream_lru_arb: priority order, LRU update, packet
// lock, backpressure, full push/pop and asynchronous reset mid-packet.
module tb_vx_stream_lru_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid_in = '0;
    logic [3:0]  last_in = '0;
    logic [31:0] d [4];
    logic [127:0] data_in;
    logic [3:0]  ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic        last_out;
    logic [1:0]  sel_out;
    logic        ready_out = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    assign data_in = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    vx_stream_lru_arb #(.NUM_REQS(4), .DATAW(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid_in  (valid_in),
        .i_data_in   (data_in),
        .i_last_in   (last_in),
        .o_ready_in  (ready_in),
        .o_valid_out (valid_out),
        .o_data_out  (data_out),
        .o_last_out  (last_out),
        .o_sel_out   (sel_out),
        .i_ready_out (ready_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        valid_in  = v;
        last_in   = l;
        ready_out = r;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_lru [4];
        exp_lru = '{0, 1, 3, 2};
        for (int i = 0; i < 4; i++) d[i] = 32'hA000_0000 | 32'(i);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_data",  64'(data_out),  64'd0);
        check("rst_sel",   64'(sel_out),   64'd0);
        check("rst_last",  64'(last_out),  64'd0);
        check("rst_ready", 64'(ready_in),  64'd0);
        #2 rst_n = 1'b1;
        tick;

        // Reset priority: round robin 0,1,2,3,...
        drive(4'b1111, 4'b1111, 1'b1);
        check("t1_ready0", 64'(ready_in), 64'b0001);
        for (int k = 0; k < 8; k++) begin
            tick;
            check($sformatf("t1_sel%0d", k), 64'(sel_out), 64'(k % 4));
            check($sformatf("t1_data%0d", k), 64'(data_out), 64'(32'hA000_0000 | 32'(k % 4)));
        end
        drive(4'b0000, 4'b1111, 1'b1);
        tick;
        check("t1_drain", 64'(valid_out), 64'd0);

        // LRU: grant 2 alone, then all request -> 0,1,3,2
        drive(4'b0100, 4'b1111, 1'b1);
        tick;
        check("t2_sel_first", 64'(sel_out), 64'd2);
        drive(4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick;
            check($sformatf("t2_sel%0d", k), 64'(sel_out), 64'(exp_lru[k]));
        end
        drive(4'b0000, 4'b1111, 1'b1);
        tick;

        // Lock: 3-beat packet on stream 1 while stream 0 requests
        drive(4'b0010, 4'b0000, 1'b1);
        tick;
        check("t3_b0_sel",  64'(sel_out),  64'd1);
        check("t3_b0_last", 64'(last_out), 64'd0);
        drive(4'b0011, 4'b0000, 1'b1);
        check("t3_b1_ready", 64'(ready_in), 64'b0010);
        tick;
        check("t3_b1_sel", 64'(sel_out), 64'd1);
        drive(4'b0011, 4'b0010, 1'b1);
        check("t3_b2_ready", 64'(ready_in), 64'b0010);
        tick;
        check("t3_b2_sel",  64'(sel_out),  64'd1);
        check("t3_b2_last", 64'(last_out), 64'd1);
        drive(4'b0001, 4'b1111, 1'b1);
        check("t3_s0_ready", 64'(ready_in), 64'b0001);
        tick;
        check("t3_s0_sel", 64'(sel_out), 64'd0);

        // Lock with a gap on stream 1: bubble, stream 0 held off
        drive(4'b0010, 4'b0000, 1'b1);
        tick;
        check("t3g_b0_sel", 64'(sel_out), 64'd1);
        drive(4'b0001, 4'b1111, 1'b1);
        check("t3g_gap_ready", 64'(ready_in), 64'b0010);
        tick;
        check("t3g_bubble", 64'(valid_out), 64'd0);
        drive(4'b0011, 4'b0010, 1'b1);
        check("t3g_b1_ready", 64'(ready_in), 64'b0010);
        tick;
        check("t3g_b1_sel",  64'(sel_out),  64'd1);
        check("t3g_b1_last", 64'(last_out), 64'd1);
        drive(4'b0001, 4'b1111, 1'b1);
        tick;
        check("t3g_s0_sel", 64'(sel_out), 64'd0);
        drive(4'b0000, 4'b1111, 1'b1);
        tick;

        // Backpressure on stream 3
        d[3] = 32'hD000_0000;
        drive(4'b1000, 4'b1000, 1'b0);
        check("t4_ready_a", 64'(ready_in), 64'b1000);
        tick;
        check("t4_valid_a", 64'(valid_out), 64'd1);
        check("t4_data_a",  64'(data_out),  64'hD000_0000);
        d[3] = 32'hD000_0001;
        drive(4'b1000, 4'b1000, 1'b0);
        check("t4_ready_b", 64'(ready_in), 64'b1000);
        tick;
        check("t4_hold_b", 64'(data_out), 64'hD000_0000);
        d[3] = 32'hD000_0002;
        drive(4'b1000, 4'b1000, 1'b0);
        check("t4_ready_full", 64'(ready_in), 64'b0000);
        tick;
        check("t4_hold_valid", 64'(valid_out), 64'd1);
        check("t4_hold_data",  64'(data_out),  64'hD000_0000);
        check("t4_hold_sel",   64'(sel_out),   64'd3);
        drive(4'b1000, 4'b1000, 1'b1);
        check("t4_ready_full2", 64'(ready_in), 64'b0000);
        tick;
        check("t4_drain1", 64'(data_out), 64'hD000_0001);
        check("t4_ready_c", 64'(ready_in), 64'b1000);
        tick;
        check("t4_drain2", 64'(data_out), 64'hD000_0002);
        drive(4'b0000, 4'b1000, 1'b1);
        tick;
        check("t4_empty", 64'(valid_out), 64'd0);

        // Full FIFO with simultaneous push/pop on stream 0
        d[0] = 32'hE000_0000;
        drive(4'b0001, 4'b0001, 1'b0);
        tick;
        d[0] = 32'hE000_0001;
        drive(4'b0001, 4'b0001, 1'b0);
        tick;
        d[0] = 32'hE000_0002;
        drive(4'b0001, 4'b0001, 1'b1);
        check("t5_ready_full", 64'(ready_in), 64'b0000);
        check("t5_head0", 64'(data_out), 64'hE000_0000);
        tick;
        check("t5_head1", 64'(data_out), 64'hE000_0001);
        check("t5_ready_open", 64'(ready_in), 64'b0001);
        tick;
        check("t5_head2", 64'(data_out), 64'hE000_0002);
        d[0] = 32'hE000_0003;
        #1;
        check("t5_ready_pp", 64'(ready_in), 64'b0001);
        tick;
        check("t5_head3", 64'(data_out), 64'hE000_0003);
        drive(4'b0000, 4'b0001, 1'b1);
        tick;
        check("t5_empty", 64'(valid_out), 64'd0);

        // Asynchronous reset while locked on stream 2
        drive(4'b0100, 4'b0000, 1'b1);
        tick;
        check("t6_pre_sel", 64'(sel_out), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(valid_out), 64'd0);
        #1 rst_n = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1);
        check("t6_ready", 64'(ready_in), 64'b0001);
        tick;
        check("t6_sel", 64'(sel_out), 64'd0);
        check("t6_valid", 64'(valid_out), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
